// File: rtl/snoopy_sprite_renderer.sv
// Redraws the Snoopy sprite on each frame tick: erases the previous box, then
// plots the ROM bitmap at the new row, one pixel write per cycle.
module snoopy_sprite_renderer #(
    parameter int unsigned SPRITE_W     = 16,
    parameter int unsigned SPRITE_H     = 16,
    parameter int unsigned SNOOPY_X     = 20,
    parameter int unsigned SCREEN_H     = 120,
    parameter logic [2:0]  BG_COLOUR    = 3'b000,
    parameter logic [2:0]  TRANS_COLOUR = 3'b111
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [6:0] snoopy_y,
    output logic [7:0] rom_addr,
    input  logic [2:0] rom_data,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);
    localparam int unsigned N        = SPRITE_W * SPRITE_H;
    localparam int unsigned IDX_W    = 8;
    localparam logic [IDX_W-1:0] LAST_IDX = 8'(N - 1);
    localparam logic [7:0] SCREEN_H8 = 8'(SCREEN_H);

    typedef enum logic [2:0] {IDLE, ERASE, DRAW, DRAIN, DONE} state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [6:0]       drawn_y, drawn_y_n;
    logic [6:0]       new_y, new_y_n;
    logic             drawn_valid, drawn_valid_n;
    logic [7:0]       rom_addr_n;
    logic             busy_n, done_n;

    // Pixel stage: position, clip-qualified strobe and whether colour comes from the ROM
    logic             pix_plot, pix_plot_n;
    logic             pix_rom, pix_rom_n;
    logic [7:0]       pix_x, pix_x_n;
    logic [6:0]       pix_y, pix_y_n;
    logic [7:0]       pix_row;

    function automatic logic [7:0] col_x(input logic [IDX_W-1:0] i);
        return 8'(SNOOPY_X) + 8'(32'(i) % SPRITE_W);
    endfunction

    // Row sum is 8 bits wide so rows past 127 clip instead of wrapping
    function automatic logic [7:0] row_y(input logic [6:0] base, input logic [IDX_W-1:0] i);
        return {1'b0, base} + 8'(32'(i) / SPRITE_W);
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= '0;
            drawn_y     <= '0;
            new_y       <= '0;
            drawn_valid <= 1'b0;
            rom_addr    <= '0;
            pix_plot    <= 1'b0;
            pix_rom     <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            drawn_y     <= drawn_y_n;
            new_y       <= new_y_n;
            drawn_valid <= drawn_valid_n;
            rom_addr    <= rom_addr_n;
            pix_plot    <= pix_plot_n;
            pix_rom     <= pix_rom_n;
            pix_x       <= pix_x_n;
            pix_y       <= pix_y_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

    always_comb begin
        state_n       = state;
        idx_n         = idx;
        drawn_y_n     = drawn_y;
        new_y_n       = new_y;
        drawn_valid_n = drawn_valid;
        rom_addr_n    = rom_addr;
        pix_plot_n    = 1'b0;
        pix_rom_n     = 1'b0;
        pix_x_n       = pix_x;
        pix_y_n       = pix_y;
        pix_row       = '0;

        case (state)
            IDLE: begin
                if (frame_tick) begin
                    new_y_n = snoopy_y;
                    idx_n   = '0;
                    if (drawn_valid && (snoopy_y == drawn_y)) state_n = DONE;
                    else if (drawn_valid)                     state_n = ERASE;
                    else                                      state_n = DRAW;
                end
            end
            ERASE: begin
                if (idx == LAST_IDX) begin
                    idx_n   = '0;
                    state_n = DRAW;
                end else begin
                    idx_n = idx + 8'd1;
                end
            end
            DRAW: begin
                // ROM word for idx arrives next cycle; stage its position now
                pix_row    = row_y(new_y, idx);
                pix_plot_n = (pix_row < SCREEN_H8);
                pix_rom_n  = 1'b1;
                pix_x_n    = col_x(idx);
                pix_y_n    = pix_row[6:0];
                if (idx == LAST_IDX) begin
                    idx_n   = '0;
                    state_n = DRAIN;
                end else begin
                    idx_n = idx + 8'd1;
                end
            end
            DRAIN: state_n = DONE;
            DONE: begin
                drawn_y_n     = new_y;
                drawn_valid_n = 1'b1;
                state_n       = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Erase pixels are known up front, so they are staged for the cycle they plot in
        if (state_n == ERASE) begin
            pix_row    = row_y(drawn_y, idx_n);
            pix_plot_n = (pix_row < SCREEN_H8);
            pix_rom_n  = 1'b0;
            pix_x_n    = col_x(idx_n);
            pix_y_n    = pix_row[6:0];
        end

        if (state_n == DRAW) rom_addr_n = idx_n;

        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

    // Colour and transparency depend on the ROM word arriving this cycle
    always_comb begin
        vga_plot   = pix_plot && !(pix_rom && (rom_data == TRANS_COLOUR));
        vga_colour = pix_plot ? (pix_rom ? rom_data : BG_COLOUR) : 3'b000;
    end

    assign vga_x = pix_x;
    assign vga_y = pix_y;

endmodule

// File: tb/tb_snoopy_sprite_renderer.sv
// Bench for snoopy_sprite_renderer: directed frames plus random ROM/rows, compared
// against a per-frame list of expected plots built from the sprite rules.
module tb_snoopy_sprite_renderer;
    localparam int N  = 256;
    localparam int SW = 16;
    localparam int SX = 20;
    localparam int SH = 120;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic [6:0] snoopy_y = '0;
    logic [7:0] rom_addr;
    logic [2:0] rom_data = '0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    logic [2:0]  rom [N];
    logic [17:0] exp_q[$];
    logic [17:0] got_q[$];
    bit          m_valid = 1'b0;
    int          m_drawn = 0;

    snoopy_sprite_renderer dut (
        .clock      (clock),
        .reset      (reset),
        .frame_tick (frame_tick),
        .snoopy_y   (snoopy_y),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rom_data <= rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_rom(input bit opaque);
        for (int i = 0; i < N; i++)
            rom[i] = opaque ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 7));
    endtask

    // Expected plot list for one tick: erase the old box (if any), then draw the new one
    task automatic build_expected(input int y, output int exp_busy);
        int r;
        exp_q.delete();
        if (m_valid && y == m_drawn) begin
            exp_busy = 1;
        end else begin
            if (m_valid)
                for (int i = 0; i < N; i++) begin
                    r = m_drawn + i / SW;
                    if (r < SH) exp_q.push_back({8'(SX + i % SW), 7'(r), 3'b000});
                end
            for (int i = 0; i < N; i++) begin
                r = y + i / SW;
                if (r < SH && rom[i] != 3'b111) exp_q.push_back({8'(SX + i % SW), 7'(r), rom[i]});
            end
            exp_busy = m_valid ? 2 * N + 2 : N + 2;
        end
        m_valid = 1'b1;
        m_drawn = y;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_plot"},   32'(vga_plot),   0);
        check({tag, "_busy"},   32'(busy),       0);
        check({tag, "_done"},   32'(done),       0);
        check({tag, "_x"},      32'(vga_x),      0);
        check({tag, "_y"},      32'(vga_y),      0);
        check({tag, "_colour"}, 32'(vga_colour), 0);
        check({tag, "_addr"},   32'(rom_addr),   0);
    endtask

    // One tick; tick_at injects a second tick mid-update, rst_at resets mid-update
    task automatic run_frame(input string tag, input int y, input int tick_at, input int rst_at);
        int  exp_busy, cyc, busy_cnt, done_cnt, done_cyc, first_busy, bad_y, n;
        bit  finished;
        build_expected(y, exp_busy);
        got_q.delete();
        @(negedge clock);
        snoopy_y   = 7'(y);
        frame_tick = 1'b1;
        @(posedge clock);
        #1 frame_tick = 1'b0;
        cyc = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1; first_busy = -1; bad_y = 0;
        finished = 1'b0;
        while (!finished && cyc < 700) begin
            @(negedge clock);
            cyc++;
            if (vga_plot) begin
                got_q.push_back({vga_x, vga_y, vga_colour});
                if (int'(vga_y) >= SH) bad_y++;
            end
            if (busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (done_cyc >= 0 && !busy) finished = 1'b1;
            if (cyc == tick_at) begin
                frame_tick = 1'b1;
                snoopy_y   = 7'($urandom);
            end else begin
                frame_tick = 1'b0;
            end
            if (cyc == rst_at) begin
                reset = 1'b0;
                #1 check_idle_outputs({tag, "_rst"});
                @(negedge clock);
                reset   = 1'b1;
                m_valid = 1'b0;
                return;
            end
        end
        frame_tick = 1'b0;
        check({tag, "_finished"},   32'(finished),   1);
        check({tag, "_busy_rise"},  32'(first_busy), 1);
        check({tag, "_busy_len"},   32'(busy_cnt),   32'(exp_busy));
        check({tag, "_done_cyc"},   32'(done_cyc),   32'(exp_busy));
        check({tag, "_done_cnt"},   32'(done_cnt),   1);
        check({tag, "_row_clip"},   32'(bad_y),      0);
        check({tag, "_plot_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_plot%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        fill_rom(1'b1);
        repeat (3) @(negedge clock);
        check_idle_outputs("reset");
        reset = 1'b1;

        run_frame("first_y100", 100, -1, -1);
        run_frame("move_y80",    80, -1, -1);
        run_frame("skip_y80",    80, -1, -1);
        run_frame("clip_y110",  110, -1, -1);
        run_frame("clip_y127",  127, -1, -1);

        fill_rom(1'b1);
        rom[5] = 3'b111;
        run_frame("trans5_y40",  40, -1, -1);

        fill_rom(1'b0);
        run_frame("tick_in_erase", 60, 50, -1);
        run_frame("rst_in_draw",   90, -1, 300);
        run_frame("after_rst",     90, -1, -1);

        for (int k = 0; k < 3; k++) begin
            fill_rom(1'b0);
            run_frame($sformatf("rand%0d", k), int'($urandom_range(0, 127)), -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/snoopy_sprite_renderer.md
Name: snoopy_sprite_renderer

Overview:
- Consumer of the Snoopy vertical position produced by the vertical FSM.
- On each frame tick, erases Snoopy's previously drawn sprite box from the framebuffer and redraws the sprite at the new y.
- Emits one pixel write per cycle to the VGA adapter plot interface.
- Reads the sprite bitmap from an external synchronous ROM with 1-cycle read latency.

Parameters:
- SPRITE_W, 16, sprite width in pixels.
- SPRITE_H, 16, sprite height in pixels. SPRITE_W*SPRITE_H <= 256.
- SNOOPY_X, 20, fixed left column of the sprite on screen.
- SCREEN_H, 120, visible rows. Rows >= SCREEN_H are never plotted.
- BG_COLOUR, 3'b000, colour used to erase.
- TRANS_COLOUR, 3'b111, ROM colour treated as transparent (not plotted).

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse requesting a redraw.
- snoopy_y  in  7  sprite top row from the vertical FSM, sampled on frame_tick.
- rom_addr  out  8  sprite ROM address, row-major (row*SPRITE_W+col).
- rom_data  in  3  ROM colour, valid the cycle after rom_addr.
- vga_x  out  8  pixel column.
- vga_y  out  7  pixel row.
- vga_colour  out  3  pixel colour.
- vga_plot  out  1  write strobe; vga_x, vga_y and vga_colour are valid when high.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse when an update completes.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE. All outputs 0. Internal registers drawn_y=0, new_y=0, drawn_valid=0, counters 0.
- Let N=SPRITE_W*SPRITE_H. Pixel counter idx runs 0..N-1; col = idx mod SPRITE_W, row = idx / SPRITE_W, col fastest.
- IDLE:
  - On frame_tick, latch new_y=snoopy_y.
  - If drawn_valid and new_y==drawn_y, go to DONE (no plots).
  - Else if drawn_valid, go to ERASE.
  - Else go to DRAW.
- ERASE (N cycles): each cycle drives vga_x=SNOOPY_X+col, vga_y=drawn_y+row, vga_colour=BG_COLOUR, vga_plot=1, except plot=0 when drawn_y+row >= SCREEN_H. After idx=N-1, clear idx and go to DRAW.
- DRAW (N cycles): cycle k drives rom_addr=k. A 1-stage pipeline carries x, y and the clip flag.
  - In cycle k+1, vga_colour=rom_data and vga_plot=1 for pixel k, unless rom_data==TRANS_COLOUR or that pixel is clipped.
  - Pixel N-1 is plotted in DRAIN.
- DRAIN (1 cycle): emits the last pipelined pixel, then go to DONE.
- DONE (1 cycle): done=1, drawn_y<=new_y, drawn_valid<=1, then IDLE.
- Row arithmetic is 8-bit, no wrap: drawn_y+row is computed in 8 bits so 127+15=142 is clipped. vga_y carries the low 7 bits only when plot=1. Column arithmetic is 8-bit; SNOOPY_X+SPRITE_W <= 160 by parameter choice.
- busy=1 in every state except IDLE. busy rises the cycle after frame_tick is sampled.
- Busy lengths:
  - Full update: 2N+2 cycles.
  - First frame: N+2 cycles.
  - Skip: 1 cycle.
- frame_tick while busy is ignored, not queued. snoopy_y changes while busy have no effect.
- vga_plot is 0 in IDLE and DONE, and 0 in the first DRAW cycle. rom_addr holds its last value outside DRAW.
- Reset asserted mid-update: immediate return to IDLE with drawn_valid=0. The next frame_tick draws without erasing.

Test Plan:
- Reset, then frame_tick with snoopy_y=100: exactly 256 plots, all from the ROM. First plot at (20,100) with colour=ROM[0]; last at (35,115) with colour=ROM[255]. done pulses 258 cycles after the tick.
- Then frame_tick with snoopy_y=80: 256 erase plots covering (20..35,100..115) with colour 000, followed by 256 draw plots at rows 80..95. busy lasts 514 cycles.
- frame_tick again with snoopy_y=80: no plots, busy high 1 cycle, done pulses once.
- Draw at snoopy_y=110: only rows 110..119 are plotted (160 plots with an opaque ROM). No plot ever has vga_y >= 120.
- ROM word 5 = 3'b111: pixel (25,y) is never plotted; all other 255 pixels are plotted.
- frame_tick pulsed mid-ERASE: ignored, and plot count is unchanged. Reset pulsed mid-DRAW: outputs go to 0 immediately. The next tick performs DRAW only (256 plots, no erase).
